gpr_wb_queue: RTL and testbench
===============================

# gpr_wb_queue

Writeback queue that drives the write port of the `gpr` register file (`rd`, `regwrite`, `wdata`). It accepts results from the execute stage over a valid/ready handshake, buffers them in order, and retires one entry per cycle into the `gpr`. Read stages present `rs1`/`rs2` to it and receive bypass data for registers whose newest value is still pending in the queue.

## Interface
- `DEPTH`, 4 — queue entries; power of two, at least 2
- `AW`, 5 — register index width
- `DW`, 32 — data width
- `clk`  in  1  — clock; all state updates on the rising edge
- `reset`  in  1  — asynchronous, active-low; clears the queue
- `in_valid`  in  1  — producer has a result
- `in_ready`  out  1  — queue can accept; equals `!full`
- `in_rd`  in  AW  — destination register of the result
- `in_data`  in  DW  — result value
- `wb_hold`  in  1  — blocks retirement this cycle (the gpr write port is in use elsewhere)
- `regwrite`  out  1  — write strobe to the gpr
- `rd`  out  AW  — gpr write index
- `wdata`  out  DW  — gpr write data
- `rs1`, `rs2`  in  AW  — read indices being presented to the gpr
- `byp1_hit`, `byp2_hit`  out  1  — a pending entry matches `rs1` / `rs2`
- `byp1_data`, `byp2_data`  out  DW  — value from the newest matching entry
- `count`  out  log2(DEPTH)+1  — number of valid entries

## Operation
- Circular buffer with a head pointer, a tail pointer and `count`. Pointers wrap modulo `DEPTH`.
- Push: occurs when `in_valid && in_ready`. The entry {`in_rd`, `in_data`} is written at the tail.
  - If `in_rd == 0`, the handshake completes but nothing is stored, because r0 is hardwired to zero.
- Retire: `regwrite = (count != 0) && !wb_hold`. `rd` and `wdata` come from the head entry.
  - The head advances on every edge where `regwrite` is 1.
- When empty, `rd = 0` and `wdata = 0`. They are driven from the reset-cleared head or muxed to 0; they never show stale data.
- `in_ready = (count != DEPTH)`.
  - A full queue refuses input even if it retires in the same cycle. No push-while-full.
- Simultaneous push and retire on a non-full queue leaves `count` unchanged, and both pointers advance.
- Bypass is combinational across all valid entries, including the head being retired this cycle.
  - The newest (closest to tail) matching entry wins.
  - `rsN == 0` never hits. On a miss, `bypN_data = 0`.
- Order is strictly FIFO. Two pending writes to the same register retire oldest first.
- Reset state while `reset == 0`: `count = 0`, both pointers 0, `in_ready = 1`, `regwrite = 0`, `rd = 0`, `wdata = 0`, both hit outputs 0, both bypass data outputs 0.
  - Reset asserted mid-operation discards every pending entry immediately, asynchronously. No partial write reaches the gpr afterwards.

## Timing
- Push-to-write latency is 1 cycle. An entry pushed at edge N into an empty queue shows `regwrite = 1` in the cycle after edge N and is written into the gpr at edge N+1.
- There is no same-cycle passthrough from `in_*` to `rd`/`wdata`/`regwrite` or to the bypass outputs.
- `regwrite`, `rd` and `wdata` depend only on registered state plus `wb_hold`.
- `in_ready` depends only on registered state.
- Bypass outputs depend combinationally on `rs1`/`rs2` and registered state.
- Sustained throughput is 1 entry per cycle with `wb_hold = 0`.
- `count` is at most `DEPTH` at all times. It never underflows.

## Test plan
- Reset and basic write:
  - Release `reset`, then push {rd=1, data=0x1234_5678} for one cycle.
  - Next cycle: `regwrite=1`, `rd=1`, `wdata=0x12345678`. The cycle after: `regwrite=0`, `count=0`.
- Fill and back-pressure:
  - Hold `wb_hold=1` and push 4 entries (rd=1..4, data=0xA1..0xA4).
  - `in_ready` drops after the 4th push, and a 5th push is refused.
  - Release `wb_hold`: writes appear in order rd=1..4 on 4 consecutive cycles.
- r0 discard: push rd=0 with data 0xFFFF_FFFF.
  - `in_ready=1`, `count` stays 0, `regwrite` is never asserted, and `rs1=0` gives `byp1_hit=0`.
- Bypass priority:
  - With `wb_hold=1`, push {8, 0x11} then {8, 0x22}, and set `rs1=8`, `rs2=9`.
  - Required: `byp1_hit=1`, `byp1_data=0x22`, `byp2_hit=0`, `byp2_data=0`.
  - After both retire, `byp1_hit=0`.
- Simultaneous push/retire and wrap:
  - Stream 10 back-to-back pushes (rd=1..10) with `wb_hold=0`.
  - `count` stays at 1 after the first push, and the writes are in order with no gaps.
  - The pointers wrap past `DEPTH` without loss.
- Asynchronous reset mid-operation:
  - With 3 entries pending under `wb_hold=1`, pulse `reset` low between edges.
  - Outputs clear immediately: `regwrite=0`, `count=0`, `in_ready=1`. No stale write occurs after release.

Source files
------------

// File: rtl/gpr_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_queue_if
// Description : Producer, retirement and bypass signals of the gpr writeback
//               queue, grouped for connection between the queue and its users.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpr_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic [DW-1:0]   in_data;
    logic            wb_hold;
    logic            regwrite;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   wdata;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            byp1_hit;
    logic            byp2_hit;
    logic [DW-1:0]   byp1_data;
    logic [DW-1:0]   byp2_data;
    logic [c_CW-1:0] count;

    modport slave (
        input  in_valid, in_rd, in_data, wb_hold, rs1, rs2,
        output in_ready, regwrite, rd, wdata,
               byp1_hit, byp2_hit, byp1_data, byp2_data, count
    );

    modport master (
        output in_valid, in_rd, in_data, wb_hold, rs1, rs2,
        input  in_ready, regwrite, rd, wdata,
               byp1_hit, byp2_hit, byp1_data, byp2_data, count
    );
endinterface
`default_nettype wire

// File: rtl/gpr_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_queue
// Description : In-order writeback queue feeding the gpr write port, with
//               newest-entry bypass for two read indices.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    gpr_wb_queue_if.slave bus
);
    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [AW-1:0]   r_rd   [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic            w_nempty;
    logic            w_push;
    logic            w_pop;
    logic [c_PW-1:0] w_idx  [DEPTH];
    logic            w_live [DEPTH];
    logic            w_h1;
    logic            w_h2;
    logic [DW-1:0]   w_d1;
    logic [DW-1:0]   w_d2;

    assign w_nempty     = (r_count != '0);
    assign bus.in_ready = (r_count != c_FULL);
    assign bus.regwrite = w_nempty && !bus.wb_hold;
    assign bus.rd       = w_nempty ? r_rd[r_head]   : '0;
    assign bus.wdata    = w_nempty ? r_data[r_head] : '0;
    assign bus.count    = r_count;

    // r0 writes complete the handshake but are never stored
    assign w_push = bus.in_valid && bus.in_ready && (bus.in_rd != '0);
    assign w_pop  = bus.regwrite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: reads are qualified by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= bus.in_rd;
            r_data[r_tail] <= bus.in_data;
        end
    end

    // Slot k is the k-th oldest entry; pointer wrap is free for power-of-two DEPTH
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_idx[k]  = r_head + c_PW'(k);
        assign w_live[k] = (c_CW'(k) < r_count);
    end

    always_comb begin
        w_h1 = 1'b0;
        w_h2 = 1'b0;
        w_d1 = '0;
        w_d2 = '0;
        // Oldest to newest so the newest match overrides
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (bus.rs1 != '0) && (r_rd[w_idx[k]] == bus.rs1)) begin
                w_h1 = 1'b1;
                w_d1 = r_data[w_idx[k]];
            end
            if (w_live[k] && (bus.rs2 != '0) && (r_rd[w_idx[k]] == bus.rs2)) begin
                w_h2 = 1'b1;
                w_d2 = r_data[w_idx[k]];
            end
        end
    end

    assign bus.byp1_hit  = w_h1;
    assign bus.byp2_hit  = w_h2;
    assign bus.byp1_data = w_d1;
    assign bus.byp2_data = w_d2;
endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_queue
// Description : Self-checking bench for gpr_wb_queue: vector table, directed
//               corner sequences and random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    gpr_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    gpr_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic          v;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          hold;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          rw;
        logic [AW-1:0] erd;
        logic [DW-1:0] ewd;
        logic [2:0]    cnt;
        logic          rdy;
        logic          h1;
        logic [DW-1:0] d1;
        logic          h2;
        logic [DW-1:0] d2;
    } vec_t;
    vec_t tbl[11];

    logic          obs_rw, obs_rdy, obs_h1, obs_h2;
    logic [AW-1:0] obs_rd;
    logic [DW-1:0] obs_wd, obs_d1, obs_d2;
    logic [2:0]    obs_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void lookup(input logic [AW-1:0] rs, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endfunction

    // One cycle: drive at the falling edge, compare against the model, then advance it
    task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input logic h, input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic          e_rw, e_rdy, e_h1, e_h2;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_wd, e_d1, e_d2;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_rd    = r;
        bus.in_data  = d;
        bus.wb_hold  = h;
        bus.rs1      = a;
        bus.rs2      = b;
        #1;
        e_rdy = (q.size() != DEPTH);
        e_rw  = (q.size() != 0) && !h;
        e_rd  = (q.size() != 0) ? q[0].rd   : '0;
        e_wd  = (q.size() != 0) ? q[0].data : '0;
        lookup(a, e_h1, e_d1);
        lookup(b, e_h2, e_d2);
        obs_rw  = bus.regwrite;
        obs_rdy = bus.in_ready;
        obs_rd  = bus.rd;
        obs_wd  = bus.wdata;
        obs_cnt = bus.count;
        obs_h1  = bus.byp1_hit;
        obs_d1  = bus.byp1_data;
        obs_h2  = bus.byp2_hit;
        obs_d2  = bus.byp2_data;
        chk("model in_ready", 32'(obs_rdy), 32'(e_rdy));
        chk("model count",    32'(obs_cnt), 32'(q.size()));
        chk("model regwrite", 32'(obs_rw),  32'(e_rw));
        chk("model rd",       32'(obs_rd),  32'(e_rd));
        chk("model wdata",    obs_wd,       e_wd);
        chk("model byp1_hit", 32'(obs_h1),  32'(e_h1));
        chk("model byp1_data", obs_d1,      e_d1);
        chk("model byp2_hit", 32'(obs_h2),  32'(e_h2));
        chk("model byp2_data", obs_d2,      e_d2);
        @(posedge clk);
        if (e_rw) void'(q.pop_front());
        if (v && e_rdy && (r != 0)) q.push_back('{rd: r, data: d});
    endtask

    initial begin
        tbl[0]  = '{1, 1, 32'h1234_5678, 0, 0, 0,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,         0, 1, 0,  1, 1, 32'h1234_5678, 1, 1, 1, 32'h1234_5678, 0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,         0, 1, 0,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};
        tbl[3]  = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};
        tbl[4]  = '{0, 0, 32'h0,         0, 0, 0,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};
        tbl[5]  = '{1, 8, 32'h11,        1, 8, 9,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};
        tbl[6]  = '{1, 8, 32'h22,        1, 8, 9,  0, 8, 32'h11,        1, 1, 1, 32'h11,        0, 32'h0};
        tbl[7]  = '{0, 0, 32'h0,         1, 8, 9,  0, 8, 32'h11,        2, 1, 1, 32'h22,        0, 32'h0};
        tbl[8]  = '{0, 0, 32'h0,         0, 8, 9,  1, 8, 32'h11,        2, 1, 1, 32'h22,        0, 32'h0};
        tbl[9]  = '{0, 0, 32'h0,         0, 8, 9,  1, 8, 32'h22,        1, 1, 1, 32'h22,        0, 32'h0};
        tbl[10] = '{0, 0, 32'h0,         0, 8, 9,  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0};

        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.wb_hold  = 1'b0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        reset        = 1'b1;
        #1 reset     = 1'b0;
        #12;
        chk("reset count",    32'(bus.count),    0);
        chk("reset in_ready", 32'(bus.in_ready), 1);
        chk("reset regwrite", 32'(bus.regwrite), 0);
        chk("reset rd",       32'(bus.rd),       0);
        chk("reset wdata",    bus.wdata,         0);
        chk("reset byp1_hit", 32'(bus.byp1_hit), 0);
        chk("reset byp2_hit", 32'(bus.byp2_hit), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].hold, tbl[i].rs1, tbl[i].rs2);
            chk($sformatf("vec%0d regwrite", i), 32'(obs_rw),  32'(tbl[i].rw));
            chk($sformatf("vec%0d rd", i),       32'(obs_rd),  32'(tbl[i].erd));
            chk($sformatf("vec%0d wdata", i),    obs_wd,       tbl[i].ewd);
            chk($sformatf("vec%0d count", i),    32'(obs_cnt), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d in_ready", i), 32'(obs_rdy), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d byp1_hit", i), 32'(obs_h1),  32'(tbl[i].h1));
            chk($sformatf("vec%0d byp1_data", i), obs_d1,      tbl[i].d1);
            chk($sformatf("vec%0d byp2_hit", i), 32'(obs_h2),  32'(tbl[i].h2));
            chk($sformatf("vec%0d byp2_data", i), obs_d2,      tbl[i].d2);
        end

        // Fill under hold, refuse a fifth push, then drain in order
        for (int i = 1; i <= 4; i++) step(1, AW'(i), 32'hA0 + 32'(i), 1, 0, 0);
        step(1, 5, 32'hA5, 1, 0, 0);
        chk("full in_ready", 32'(obs_rdy), 0);
        chk("full count",    32'(obs_cnt), 4);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("drain%0d regwrite", i), 32'(obs_rw), 1);
            chk($sformatf("drain%0d rd", i),       32'(obs_rd), 32'(i));
            chk($sformatf("drain%0d wdata", i),    obs_wd,      32'hA0 + 32'(i));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("drained count", 32'(obs_cnt), 0);

        // Back-to-back stream wraps the pointers
        for (int i = 1; i <= 10; i++) begin
            step(1, AW'(i), 32'h100 + 32'(i), 0, 0, 0);
            if (i > 1) begin
                chk($sformatf("stream%0d count", i), 32'(obs_cnt), 1);
                chk($sformatf("stream%0d rd", i),    32'(obs_rd),  32'(i - 1));
            end
        end
        step(0, 0, 0, 0, 0, 0);
        chk("stream last rd", 32'(obs_rd), 10);

        // Asynchronous reset between edges with three entries pending
        for (int i = 1; i <= 3; i++) step(1, AW'(i + 20), 32'hC0 + 32'(i), 1, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rs1      = 21;
        #2 reset     = 1'b0;
        #1;
        chk("areset regwrite", 32'(bus.regwrite), 0);
        chk("areset count",    32'(bus.count),    0);
        chk("areset in_ready", 32'(bus.in_ready), 1);
        chk("areset wdata",    bus.wdata,         0);
        chk("areset byp1_hit", 32'(bus.byp1_hit), 0);
        #1 reset = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 21, 22);
            chk($sformatf("post-reset%0d regwrite", i), 32'(obs_rw), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
